// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with a valid/ready handshake.
//
// AND, OR, ADD and SUB (and illegal codes, and zero-amount shifts) finish in
// the cycle they are accepted. SLL/SRL by n >= 1 run one bit per cycle in the
// SHIFT state, so the stage back-pressures upstream for n cycles.
//
// Ports:
//   clk        rising-edge clock
//   res_n      asynchronous active-low reset
//   in_valid   upstream offers an operation
//   in_ready   stage accepts an operation this cycle (IDLE and output free)
//   alu_ctl    operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 SLL, 0101 SRL
//   op_a       first operand; value that is shifted
//   op_b       second operand; shift amount is op_b[SHW-1:0]
//   out_valid  result/zero/illegal are valid
//   out_ready  downstream consumes the result
//   result     registered result
//   zero       registered (result == 0)
//   illegal    registered; delivered op had an unknown alu_ctl
//   busy       shift in progress
module alu_exec #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLL = 4'b0011;
  localparam logic [3:0] CTL_SRL = 4'b0101;

  localparam logic [SHW-1:0]   CNT_ZERO = {SHW{1'b0}};
  localparam logic [SHW-1:0]   CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_left_q, dir_left_d;

  logic             accept_s;
  logic [SHW-1:0]   shamt_s;
  logic             is_shift_s;
  logic             legal_s;
  logic [WIDTH-1:0] single_res_s;
  logic [WIDTH-1:0] shifted_s;

  // Handshake: in_ready depends only on registered state and out_ready.
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
  assign shamt_s  = op_b[SHW-1:0];

  // Decode the incoming op into its single-cycle result and legality.
  always_comb begin
    single_res_s = VAL_ZERO;
    legal_s      = 1'b0;
    is_shift_s   = 1'b0;
    case (alu_ctl)
      CTL_AND: begin single_res_s = op_a & op_b; legal_s = 1'b1; end
      CTL_OR:  begin single_res_s = op_a | op_b; legal_s = 1'b1; end
      CTL_ADD: begin single_res_s = op_a + op_b; legal_s = 1'b1; end
      CTL_SUB: begin single_res_s = op_a - op_b; legal_s = 1'b1; end
      // A shift only reaches the single-cycle path with a zero amount.
      CTL_SLL: begin single_res_s = op_a; legal_s = 1'b1; is_shift_s = 1'b1; end
      CTL_SRL: begin single_res_s = op_a; legal_s = 1'b1; is_shift_s = 1'b1; end
      default: begin single_res_s = VAL_ZERO; legal_s = 1'b0; is_shift_s = 1'b0; end
    endcase
  end

  // One-bit step of the iterative shifter, zero-filling the vacated end.
  always_comb begin
    if (dir_left_q) begin
      shifted_s = {acc_q[WIDTH-2:0], 1'b0};
    end else begin
      shifted_s = {1'b0, acc_q[WIDTH-1:1]};
    end
  end

  // Next-state and output-register logic for the IDLE/SHIFT controller.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dir_left_d  = dir_left_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (is_shift_s && (shamt_s != CNT_ZERO)) begin
            acc_d      = op_a;
            cnt_d      = shamt_s;
            dir_left_d = (alu_ctl == CTL_SLL);
            state_d    = ST_SHIFT;
          end else begin
            // A new result replacing one consumed at this same edge keeps
            // out_valid high with no bubble.
            result_d    = single_res_s;
            zero_d      = (single_res_s == VAL_ZERO);
            illegal_d   = !legal_s;
            out_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d = shifted_s;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d    = shifted_s;
          zero_d      = (shifted_s == VAL_ZERO);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by res_n.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= VAL_ZERO;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      acc_q       <= VAL_ZERO;
      cnt_q       <= CNT_ZERO;
      dir_left_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dir_left_q  <= dir_left_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and short random stimulus for alu_exec, checked
// against a transaction-level model (whole shift computed at accept, result
// released after n cycles) plus hand-computed literal expectations.
module tb_alu_exec;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    alu_ctl = 4'b0000;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          zero;
  logic          illegal;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec #(.WIDTH(W)) dut (
    .clk(clk), .res_n(res_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: delivered output plus one pending shift result.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_result = '0;
  logic         m_zero = 1'b0;
  logic         m_illegal = 1'b0;
  int           m_wait = 0;
  logic [W-1:0] m_pend = '0;

  function automatic logic m_in_ready();
    return (m_wait == 0) && (!m_valid || out_ready);
  endfunction

  // Model update at each edge (and at reset assertion).
  always @(posedge clk or negedge res_n) begin
    logic acc;
    logic [W-1:0] r;
    logic leg;
    int n;
    if (!res_n) begin
      m_valid = 1'b0; m_result = '0; m_zero = 1'b0; m_illegal = 1'b0; m_wait = 0;
    end else begin
      acc = in_valid && m_in_ready();
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1; m_result = m_pend; m_zero = (m_pend == 0); m_illegal = 1'b0;
        end
      end else if (acc) begin
        n = int'(op_b % W);
        leg = 1'b1;
        r = '0;
        case (alu_ctl)
          4'b0000: r = op_a & op_b;
          4'b0001: r = op_a | op_b;
          4'b0010: r = op_a + op_b;
          4'b0110: r = op_a - op_b;
          4'b0011: r = op_a << n;
          4'b0101: r = op_a >> n;
          default: leg = 1'b0;
        endcase
        if ((alu_ctl == 4'b0011 || alu_ctl == 4'b0101) && n != 0) begin
          m_pend = r; m_wait = n;
        end else begin
          m_valid = 1'b1; m_result = r; m_zero = (r == 0); m_illegal = !leg;
        end
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    chk("in_ready", W'(in_ready), W'(m_in_ready()));
    chk("busy", W'(busy), W'(m_wait > 0));
    chk("out_valid", W'(out_valid), W'(m_valid));
    if (m_valid) begin
      chk("result", result, m_result);
      chk("zero", W'(zero), W'(m_zero));
      chk("illegal", W'(illegal), W'(m_illegal));
    end
  end

  task automatic drive(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_ctl = c; op_a = a; op_b = b; in_valid = 1'b1;
  endtask

  // Offer an op now (stage must be ready) and withdraw it after the edge.
  task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    drive(c, a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int cycles;
    int pulses;
    logic [3:0] ops [7];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0101, 4'b1111};

    #12;
    chk("rst_result", result, 32'h0);
    chk("rst_zero", W'(zero), 32'h0);
    chk("rst_out_valid", W'(out_valid), 32'h0);
    chk("rst_in_ready", W'(in_ready), 32'h1);
    chk("rst_busy", W'(busy), 32'h0);
    @(posedge clk); #1 res_n = 1'b1;

    // ADD 5 + 7
    @(negedge clk); #1;
    send(4'b0010, 32'd5, 32'd7);
    @(negedge clk);
    chk("add_result", result, 32'd12);
    chk("add_zero", W'(zero), 32'h0);
    chk("add_valid", W'(out_valid), 32'h1);
    chk("add_illegal", W'(illegal), 32'h0);

    // Back-to-back SUBs
    #1 drive(4'b0110, 32'd5, 32'd5);
    @(posedge clk); #1 drive(4'b0110, 32'd0, 32'd1);
    @(negedge clk);
    chk("sub0_result", result, 32'h0);
    chk("sub0_zero", W'(zero), 32'h1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("subm1_result", result, 32'hFFFF_FFFF);
    chk("subm1_zero", W'(zero), 32'h0);

    // SLL 1 by 4
    #1 send(4'b0011, 32'd1, 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sll4_busy", W'(busy), 32'h1);
      chk("sll4_in_ready", W'(in_ready), 32'h0);
    end
    @(negedge clk);
    chk("sll4_valid", W'(out_valid), 32'h1);
    chk("sll4_result", result, 32'h10);

    // SRL 0x8000_0000 by 31
    #1 send(4'b0101, 32'h8000_0000, 32'd31);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
      cycles++;
    end
    chk("srl31_cycles", W'(cycles), 32'd31);
    chk("srl31_result", result, 32'h1);

    // SLL by 32: amount bits are 0, single cycle
    #1 send(4'b0011, 32'h0000_ABCD, 32'd32);
    @(negedge clk);
    chk("sll32_valid", W'(out_valid), 32'h1);
    chk("sll32_result", result, 32'h0000_ABCD);
    chk("sll32_busy", W'(busy), 32'h0);

    // Backpressure on an AND, then OR accepted as out_ready rises
    #1 send(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", result, 32'h0000_00F0);
      chk("bp_in_ready", W'(in_ready), 32'h0);
    end
    #1 out_ready = 1'b1;
    send(4'b0001, 32'h1, 32'h2);
    @(negedge clk);
    chk("bp_or_valid", W'(out_valid), 32'h1);
    chk("bp_or_result", result, 32'h3);

    // Illegal code, then a legal op clears illegal
    #1 send(4'b1111, 32'h1234, 32'h5678);
    @(negedge clk);
    chk("ill_result", result, 32'h0);
    chk("ill_zero", W'(zero), 32'h1);
    chk("ill_flag", W'(illegal), 32'h1);
    #1 send(4'b0010, 32'd1, 32'd1);
    @(negedge clk);
    chk("ill_clear", W'(illegal), 32'h0);
    chk("ill_next_result", result, 32'd2);

    // Reset two cycles into an SLL by 10
    #1 send(4'b0011, 32'd3, 32'd10);
    @(posedge clk);
    @(posedge clk); #2 res_n = 1'b0;
    #1;
    chk("midrst_valid", W'(out_valid), 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_busy", W'(busy), 32'h0);
    chk("midrst_in_ready", W'(in_ready), 32'h1);
    @(negedge clk);
    @(posedge clk); #3 res_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    chk("midrst_no_pulse", W'(pulses), 32'h0);

    // Short random phase, checked by the compare process
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      alu_ctl   = ops[$urandom_range(0, 6)];
      op_a      = $urandom;
      op_b      = (alu_ctl == 4'b0011 || alu_ctl == 4'b0101) ? W'($urandom_range(0, 6)) : $urandom;
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU for the RISC-V datapath. It consumes the 4-bit ALU operation code produced by the ALU control stage, together with two operands, and returns a registered result and zero flag through a valid/ready handshake. AND, OR, ADD and SUB complete in one cycle. Logical shifts run iteratively, one bit per cycle, so the stage can stall the pipeline.

## Interface
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk  in  1  clock; all state updates on the rising edge
- res_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream offers an operation
- in_ready  out  1  stage can accept an operation this cycle
- alu_ctl  in  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 SLL, 0101 SRL
- op_a  in  WIDTH  first operand; the value that is shifted
- op_b  in  WIDTH  second operand; shift amount = op_b[SHW-1:0]
- out_valid  out  1  result, zero and illegal are valid
- out_ready  in  1  downstream consumes the result
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)
- illegal  out  1  registered; alu_ctl of the delivered op was not in the list above
- busy  out  1  shift in progress (state SHIFT)

## Operation
- States: IDLE, SHIFT.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This is a combinational function of registered state and out_ready only, never of in_valid.
- Accept: in_valid && in_ready at a rising edge. Operands and alu_ctl are sampled only at accept.
- Single-cycle ops (AND, OR, ADD, SUB, illegal, or a shift with amount 0):
  - result/zero/illegal are written at the accept edge and out_valid is set; state stays IDLE.
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow outputs.
  - SUB computes op_a - op_b.
  - A zero-amount shift returns op_a.
  - An illegal code returns result = 0, zero = 1, illegal = 1.
- Shift with amount n ≥ 1:
  - At the accept edge: load acc = op_a, cnt = n, dir = SLL/SRL; go to SHIFT. out_valid is cleared if it was consumed at this edge.
  - In SHIFT, each edge shifts acc by 1 (SRL zero-fills the MSB, SLL zero-fills the LSB) and decrements cnt.
  - At the edge where cnt goes 1 → 0: result = shifted acc, zero updated, illegal = 0, out_valid = 1, state → IDLE.
- out_valid clears at an edge where out_valid && out_ready, unless a new single-cycle op is accepted at the same edge; in that case out_valid stays 1 and the new result replaces the old.
- While out_valid && !out_ready, result/zero/illegal hold stable and in_ready = 0.
- out_ready is ignored while out_valid = 0. in_valid is ignored while in_ready = 0.

## Timing
- Reset (asynchronous, res_n low) forces:
  - state = IDLE, out_valid = 0, result = 0, zero = 0, illegal = 0, busy = 0, acc = 0, cnt = 0.
  - in_ready therefore reads 1 during and after reset.
- Reset mid-shift aborts the operation; no result is ever delivered for it.
- Latency, measured from the accept edge E0:
  - Single-cycle ops: out_valid is high in the cycle after E0.
  - Shift by n: out_valid rises after edge En, i.e. n cycles. in_ready and busy hold their SHIFT-state values for those n cycles.
- Throughput: one single-cycle op per clock when out_ready is held at 1.
- Shift by WIDTH-1 is the longest operation, WIDTH-1 cycles. The result must equal op_a shifted by WIDTH-1, e.g. 0x8000_0000 for SLL of 1 by 31.

## Test plan
- Reset then ADD: op_a = 5, op_b = 7, out_ready = 1 -> the cycle after accept shows result = 12, zero = 0, out_valid = 1, illegal = 0.
- SUB and zero flag: 5 - 5 -> result = 0, zero = 1. Then 0 - 1 -> result = 0xFFFF_FFFF, zero = 0. Back-to-back accepts on consecutive edges.
- Iterative shift: SLL of op_a = 1 by op_b = 4 -> busy = 1 and in_ready = 0 for 4 cycles, then result = 0x10. SRL of 0x8000_0000 by 31 -> result = 1 after 31 cycles. SLL by op_b = 32 (amount bits 0) -> result = op_a in 1 cycle.
- Backpressure: out_ready = 0 after an AND of 0xF0F0 with 0x0FF0 -> result = 0x00F0 holds, in_ready = 0 for 5 cycles. Raise out_ready with in_valid = 1 (OR op) -> the new result is delivered at the next edge with out_valid held at 1.
- Illegal code: alu_ctl = 1111 -> result = 0, zero = 1, illegal = 1, single cycle. The next legal op clears illegal.
- Reset mid-shift: assert res_n = 0 two cycles into an SLL by 10 -> all outputs 0 immediately, in_ready = 1. After release, no stray out_valid pulse appears.
